// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: frame state encoding and line levels.
// Imported by the transmitter and, later, the matching receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage : serial_pkg

// File: rtl/serial_tx_if.sv
// Word-in / bit-out port bundle of the serial transmitter.
// Handshake: a word transfers at a rising clock edge where valid_in & ready_out.
interface serial_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             q_out;
  logic             busy;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  q_out,
    input  busy
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output q_out,
    output busy
  );

endinterface : serial_tx_if

// File: rtl/serial_tx_bit_timer.sv
// Reloadable down-counter that paces one serial bit: ticks when it reaches 0
// while running, and reloads to DIV-1 on that tick or on an explicit load.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_zero;

  assign w_zero = (r_count == '0);
  assign o_tick = i_run && w_zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load || o_tick) begin
      r_count <= RELOAD;
    end else if (i_run) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule : bit_timer

// File: rtl/serial_tx.sv
// Framed LSB-first parallel-to-serial transmitter: start 0, data, stop 1, each
// bit held DIV clocks. Define SERIAL_TX_PARITY_EN to add an even-parity bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  serial_tx_if.slave  bus,
  output state_t      o_dbg_state
);

  localparam int IDXW = $clog2(WIDTH) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IDXW-1:0]  r_bit_idx;
  logic             r_q;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_parity;
`endif

  logic             w_handshake;
  logic             w_run;
  logic             w_tick;
  logic [WIDTH-1:0] w_shifted;

  assign w_handshake = bus.valid_in && (r_state == IDLE);
  assign w_run       = (r_state != IDLE);
  assign w_shifted   = r_shreg >> 1;

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_handshake),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  // q_out is registered alongside the state so the line never glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_q       <= LINE_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_q <= LINE_IDLE;
          if (w_handshake) begin
            r_shreg   <= bus.data_in;
            r_bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= ^bus.data_in;
`endif
            r_state   <= START;
            r_q       <= START_LVL;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_q     <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
              r_state <= PARITY;
              r_q     <= r_parity;
`else
              r_state <= STOP;
              r_q     <= STOP_LVL;
`endif
            end else begin
              r_shreg   <= w_shifted;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_q       <= w_shifted[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_q     <= STOP_LVL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_q     <= LINE_IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_q     <= LINE_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_out = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.q_out     = r_q;
  assign o_dbg_state   = r_state;

endmodule : serial_tx

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame-level model per instance (DIV=4 and DIV=1) checked
// every cycle, plus hand-written frame literals and accept-time checks.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = WIDTH + 3;
  localparam int GAP_LIT = 45;
  // frame literals, bit k = k-th bit on the line: {stop, parity, data, start}
  localparam logic [15:0] L_A5   = 16'(11'b1_0_10100101_0);
  localparam logic [15:0] L_0F   = 16'(11'b1_0_00001111_0);
  localparam logic [15:0] L_F0   = 16'(11'b1_0_11110000_0);
  localparam logic [15:0] L_5A   = 16'(11'b1_0_01011010_0);
  localparam logic [15:0] L_3C   = 16'(11'b1_0_00111100_0);
  localparam logic [15:0] L_01   = 16'(11'b1_1_00000001_0);
  localparam logic [15:0] L_81   = 16'(11'b1_0_10000001_0);
`else
  localparam int NBITS = WIDTH + 2;
  localparam int GAP_LIT = 41;
  localparam logic [15:0] L_A5   = 16'(10'b1_10100101_0);
  localparam logic [15:0] L_0F   = 16'(10'b1_00001111_0);
  localparam logic [15:0] L_F0   = 16'(10'b1_11110000_0);
  localparam logic [15:0] L_5A   = 16'(10'b1_01011010_0);
  localparam logic [15:0] L_3C   = 16'(10'b1_00111100_0);
  localparam logic [15:0] L_01   = 16'(10'b1_00000001_0);
  localparam logic [15:0] L_81   = 16'(10'b1_10000001_0);
`endif
  localparam int FRAME = NBITS * DIV;

  // clock/reset block
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  serial_tx_if #(.WIDTH(WIDTH)) bus1 ();
  serial_tx_if #(.WIDTH(WIDTH)) bus2 ();
  state_t dbg1, dbg2;

  serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1), .o_dbg_state(dbg1)
  );
  serial_tx #(.WIDTH(WIDTH), .DIV(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2), .o_dbg_state(dbg2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // frame bit k of word d as seen on the line
  function automatic logic frame_bit(input logic [WIDTH-1:0] d, input int k);
    if (k == 0) return START_LVL;
    if (k <= WIDTH) return d[k-1];
`ifdef SERIAL_TX_PARITY_EN
    if (k == WIDTH + 1) return ^d;
`endif
    return STOP_LVL;
  endfunction

  // scoreboard: expected line level for each upcoming clock cycle
  logic exp_q1[$];
  logic exp_q2[$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) exp_q1.delete();
    else if (exp_q1.size() != 0) void'(exp_q1.pop_front());
    else if (bus1.valid_in)
      for (int k = 0; k < NBITS; k++)
        for (int r = 0; r < DIV; r++) exp_q1.push_back(frame_bit(bus1.data_in, k));
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) exp_q2.delete();
    else if (exp_q2.size() != 0) void'(exp_q2.pop_front());
    else if (bus2.valid_in)
      for (int k = 0; k < NBITS; k++) exp_q2.push_back(frame_bit(bus2.data_in, k));
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("m1_q",     32'(bus1.q_out),     32'((exp_q1.size() != 0) ? exp_q1[0] : LINE_IDLE));
      chk("m1_busy",  32'(bus1.busy),      32'(exp_q1.size() != 0));
      chk("m1_ready", 32'(bus1.ready_out), 32'(exp_q1.size() == 0));
      chk("m2_q",     32'(bus2.q_out),     32'((exp_q2.size() != 0) ? exp_q2[0] : LINE_IDLE));
      chk("m2_busy",  32'(bus2.busy),      32'(exp_q2.size() != 0));
      chk("m2_ready", 32'(bus2.ready_out), 32'(exp_q2.size() == 0));
    end
  end

  // driver tasks: return just after the accepting edge with t = its cycle
  task automatic send1(input logic [WIDTH-1:0] d, input bit keep, output int t);
    bit ok = 1'b0;
    @(negedge clock);
    bus1.data_in  = d;
    bus1.valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus1.ready_out) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send1_timeout: ready_out never rose, expected within 200 cycles");
    end
    @(posedge clock); #1;
    t = cyc;
    if (!keep) bus1.valid_in = 1'b0;
  endtask

  task automatic send2(input logic [WIDTH-1:0] d);
    bit ok = 1'b0;
    @(negedge clock);
    bus2.data_in  = d;
    bus2.valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus2.ready_out) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send2_timeout: ready_out never rose, expected within 200 cycles");
    end
    @(posedge clock); #1;
    bus2.valid_in = 1'b0;
  endtask

  // walk one dut1 frame from the accept edge, checking bit levels against a literal
  task automatic watch1(input string name, input logic [15:0] lit);
    for (int c = 0; c < FRAME; c++) begin
      if (c % DIV == 1 % DIV) chk({name, "_bit"}, 32'(bus1.q_out), 32'(lit[c/DIV]));
      chk({name, "_busy"}, 32'(bus1.busy), 32'd1);
      @(posedge clock); #1;
    end
    chk({name, "_ready_end"}, 32'(bus1.ready_out), 32'd1);
    chk({name, "_busy_end"},  32'(bus1.busy),      32'd0);
  endtask

  int t1, t2, t3;

  initial begin
    bus1.data_in = '0; bus1.valid_in = 1'b0;
    bus2.data_in = '0; bus2.valid_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle_q",     32'(bus1.q_out),     32'd1);
      chk("idle_ready", 32'(bus1.ready_out), 32'd1);
      chk("idle_busy",  32'(bus1.busy),      32'd0);
    end
    chk("idle_state", 32'(dbg1), 32'(IDLE));

    send1(8'hA5, 1'b0, t1);
    watch1("a5", L_A5);

    // back-to-back with valid held high
    send1(8'h0F, 1'b1, t1);
    watch1("b2b_0f", L_0F);
    send1(8'hF0, 1'b0, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'(GAP_LIT));
    watch1("b2b_f0", L_F0);

    // data change and valid pulse mid-frame must be ignored
    send1(8'h5A, 1'b0, t1);
    fork
      watch1("mid", L_5A);
      begin
        repeat (10) @(negedge clock);
        bus1.data_in = 8'hFF; bus1.valid_in = 1'b1;
        @(negedge clock);
        bus1.valid_in = 1'b0;
      end
    join
    repeat (5) begin
      @(negedge clock);
      chk("mid_no_extra", 32'(bus1.busy), 32'd0);
    end

`ifdef SERIAL_TX_PARITY_EN
    send1(8'h01, 1'b0, t1);
    watch1("par01", L_01);
`endif

    // async reset during data bit 3
    send1(8'h00, 1'b0, t1);
    repeat ((1 + 3) * DIV + 1) begin @(posedge clock); #1; end
    chk("pre_reset_q", 32'(bus1.q_out), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async_reset_q",    32'(bus1.q_out),     32'd1);
    chk("async_reset_busy", 32'(bus1.busy),      32'd0);
    chk("async_reset_rdy",  32'(bus1.ready_out), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      chk("post_reset_idle", 32'(bus1.q_out), 32'd1);
    end
    send1(8'h3C, 1'b0, t3);
    watch1("after_rst_3c", L_3C);

    // DIV=1 instance: one clock per bit
    send2(8'h81);
    for (int c = 0; c < NBITS; c++) begin
      chk("div1_bit", 32'(bus2.q_out), 32'(L_81[c]));
      @(posedge clock); #1;
    end
    chk("div1_ready_end", 32'(bus2.ready_out), 32'd1);

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_tx
